// File: rtl/ucsbece154b_branch_resolve_pkg.sv
// Opcode constants shared by the branch-resolution slice; values mirror ucsbece154b_defines.vh.
// Constants only: no latency, no flow control.
package ucsbece154b_branch_resolve_pkg;

    localparam logic [6:0] instr_branch_op = 7'b1100011;
    localparam logic [6:0] instr_jal_op    = 7'b1101111;
    localparam logic [6:0] instr_jalr_op   = 7'b1100111;

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones.
// Latency: new value visible the cycle after inc_i; no backpressure.
module ucsbece154b_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else if (inc_i && (count_o != '1)) begin
            count_o <= count_o + ONE;
        end
    end

endmodule

// File: rtl/ucsbece154b_branch_resolve.sv
// Carries predictions through D/E, resolves them in E and drives BTB/PHT/GHR update strobes.
// Latency: outputs combinational from E state; D stalls on StallD_i, E never stalls.
module ucsbece154b_branch_resolve
    import ucsbece154b_branch_resolve_pkg::*;
#(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic                               StallD_i,
    input  logic                               FlushD_i,
    input  logic                               FlushE_i,
    input  logic [31:0]                        PCF_i,
    input  logic                               BranchTakenF_i,
    input  logic [31:0]                        BTBtargetF_i,
    input  logic [NUM_GHR_BITS-1:0]            PHTreadaddressF_i,
    input  logic [6:0]                         opE_i,
    input  logic                               ActualTakenE_i,
    input  logic [31:0]                        TargetE_i,
    output logic                               MispredictE_o,
    output logic [31:0]                        PCcorrectE_o,
    output logic                               BTBwe_o,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
    output logic [31:0]                        BTBwritedata_o,
    output logic                               PHTwe_o,
    output logic                               PHTincrement_o,
    output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
    output logic                               GHRreset_o,
    output logic [CNT_WIDTH-1:0]               BranchCount_o,
    output logic [CNT_WIDTH-1:0]               MispredictCount_o
);

    localparam int IDX = $clog2(NUM_BTB_ENTRIES);

    typedef struct packed {
        logic                    vld;
        logic [31:0]             pc;
        logic                    taken;
        logic [31:0]             tgt;
        logic [NUM_GHR_BITS-1:0] pht;
    } stage_t;

    stage_t d_q, e_q;

    // Flush outranks stall so a squashed slot never survives a held D.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            d_q <= '0;
        end else if (FlushD_i) begin
            d_q <= '0;
        end else if (!StallD_i) begin
            d_q <= '{vld: 1'b1, pc: PCF_i, taken: BranchTakenF_i,
                     tgt: BTBtargetF_i, pht: PHTreadaddressF_i};
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            e_q <= '0;
        end else if (FlushE_i) begin
            e_q <= '0;
        end else begin
            e_q <= d_q;
        end
    end

    logic is_branch, is_jump, is_ctrl, taken, tgt_mismatch;

    always_comb begin
        is_branch    = e_q.vld && (opE_i == instr_branch_op);
        is_jump      = e_q.vld && ((opE_i == instr_jal_op) || (opE_i == instr_jalr_op));
        is_ctrl      = is_branch || is_jump;
        taken        = is_branch ? ActualTakenE_i : 1'b1;
        tgt_mismatch = (e_q.tgt != TargetE_i);

        MispredictE_o = is_ctrl && ((e_q.taken != taken) || (taken && tgt_mismatch));
        PCcorrectE_o  = '0;
        if (MispredictE_o) begin
            PCcorrectE_o = taken ? TargetE_i : (e_q.pc + 32'd4);
        end

        BTBwe_o           = is_ctrl && taken && (!e_q.taken || tgt_mismatch);
        BTBwriteaddress_o = BTBwe_o ? e_q.pc[IDX+1:2] : '0;
        BTBwritedata_o    = BTBwe_o ? TargetE_i : '0;

        PHTwe_o           = is_branch;
        PHTincrement_o    = is_branch && ActualTakenE_i;
        PHTwriteaddress_o = is_branch ? e_q.pht : '0;

        GHRreset_o = MispredictE_o;
    end

    ucsbece154b_sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
        .clk     (clk),
        .reset_i (reset_i),
        .inc_i   (is_ctrl),
        .count_o (BranchCount_o)
    );

    ucsbece154b_sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
        .clk     (clk),
        .reset_i (reset_i),
        .inc_i   (MispredictE_o),
        .count_o (MispredictCount_o)
    );

endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// Directed bench for ucsbece154b_branch_resolve; a second 4-bit-counter instance shares all inputs.
module tb_ucsbece154b_branch_resolve;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        StallD_i = 1'b0, FlushD_i = 1'b0, FlushE_i = 1'b0;
    logic [31:0] PCF_i = '0;
    logic        BranchTakenF_i = 1'b0;
    logic [31:0] BTBtargetF_i = '0;
    logic [4:0]  PHTreadaddressF_i = '0;
    logic [6:0]  opE_i = OP_ALU;
    logic        ActualTakenE_i = 1'b0;
    logic [31:0] TargetE_i = '0;

    logic        mp, btbwe, phtwe, phtinc, ghrrst;
    logic [31:0] pccorr, btbdata;
    logic [4:0]  btbaddr, phtaddr;
    logic [31:0] brcnt, mpcnt;

    logic        d4_mp, d4_btbwe, d4_phtwe, d4_phtinc, d4_ghrrst;
    logic [31:0] d4_pccorr, d4_btbdata;
    logic [4:0]  d4_btbaddr, d4_phtaddr;
    logic [3:0]  d4_brcnt, d4_mpcnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_br   = 0;
    int exp_mp   = 0;

    always #5 clk = ~clk;

    ucsbece154b_branch_resolve #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset_i(reset_i), .StallD_i(StallD_i), .FlushD_i(FlushD_i), .FlushE_i(FlushE_i),
        .PCF_i(PCF_i), .BranchTakenF_i(BranchTakenF_i), .BTBtargetF_i(BTBtargetF_i),
        .PHTreadaddressF_i(PHTreadaddressF_i), .opE_i(opE_i), .ActualTakenE_i(ActualTakenE_i),
        .TargetE_i(TargetE_i), .MispredictE_o(mp), .PCcorrectE_o(pccorr), .BTBwe_o(btbwe),
        .BTBwriteaddress_o(btbaddr), .BTBwritedata_o(btbdata), .PHTwe_o(phtwe),
        .PHTincrement_o(phtinc), .PHTwriteaddress_o(phtaddr), .GHRreset_o(ghrrst),
        .BranchCount_o(brcnt), .MispredictCount_o(mpcnt)
    );

    ucsbece154b_branch_resolve #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset_i(reset_i), .StallD_i(StallD_i), .FlushD_i(FlushD_i), .FlushE_i(FlushE_i),
        .PCF_i(PCF_i), .BranchTakenF_i(BranchTakenF_i), .BTBtargetF_i(BTBtargetF_i),
        .PHTreadaddressF_i(PHTreadaddressF_i), .opE_i(opE_i), .ActualTakenE_i(ActualTakenE_i),
        .TargetE_i(TargetE_i), .MispredictE_o(d4_mp), .PCcorrectE_o(d4_pccorr), .BTBwe_o(d4_btbwe),
        .BTBwriteaddress_o(d4_btbaddr), .BTBwritedata_o(d4_btbdata), .PHTwe_o(d4_phtwe),
        .PHTincrement_o(d4_phtinc), .PHTwriteaddress_o(d4_phtaddr), .GHRreset_o(d4_ghrrst),
        .BranchCount_o(d4_brcnt), .MispredictCount_o(d4_mpcnt)
    );

    // Drive a prediction at F and wait until it sits in E (two edges, no stalls).
    task automatic load_e(input logic [31:0] pc, input logic pt, input logic [31:0] tgt, input logic [4:0] pht);
        @(negedge clk);
        opE_i = OP_ALU; StallD_i = 1'b0; FlushD_i = 1'b0; FlushE_i = 1'b0;
        PCF_i = pc; BranchTakenF_i = pt; BTBtargetF_i = tgt; PHTreadaddressF_i = pht;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Let the resolving edge pass, then park E on a non-control op.
    task automatic step();
        @(negedge clk);
        opE_i = OP_ALU;
        #1;
    endtask

    task automatic check_counts(input string tag);
        n_checks++; if (brcnt !== 32'(exp_br)) begin n_fail++; $display("FAIL %s_brcnt got %0d want %0d", tag, brcnt, exp_br); end
        n_checks++; if (mpcnt !== 32'(exp_mp)) begin n_fail++; $display("FAIL %s_mpcnt got %0d want %0d", tag, mpcnt, exp_mp); end
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if ({mp, btbwe, phtwe, phtinc, ghrrst} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes got %b want 00000", {mp, btbwe, phtwe, phtinc, ghrrst}); end
        n_checks++; if (pccorr !== 32'h0) begin n_fail++; $display("FAIL reset_pccorr got %h want 0", pccorr); end
        @(negedge clk); @(negedge clk);
        reset_i = 1'b0; StallD_i = 1'b1; opE_i = OP_BR; ActualTakenE_i = 1'b1; TargetE_i = 32'h1234;
        #1;
        n_checks++; if ({mp, btbwe, phtwe, ghrrst} !== 4'b0) begin n_fail++; $display("FAIL reset_after_strobes got %b want 0000", {mp, btbwe, phtwe, ghrrst}); end
        n_checks++; if (btbdata !== 32'h0) begin n_fail++; $display("FAIL reset_after_btbdata got %h want 0", btbdata); end
        check_counts("reset");
        StallD_i = 1'b0;
    endtask

    task automatic test_branch_mispredict();
        load_e(32'h40, 1'b0, 32'h0, 5'd3);
        opE_i = OP_BR; ActualTakenE_i = 1'b1; TargetE_i = 32'h80;
        #1;
        n_checks++; if (mp !== 1'b1) begin n_fail++; $display("FAIL bmp_mispredict got %b want 1", mp); end
        n_checks++; if (pccorr !== 32'h80) begin n_fail++; $display("FAIL bmp_pccorr got %h want 80", pccorr); end
        n_checks++; if ({btbwe, btbaddr} !== {1'b1, 5'd16}) begin n_fail++; $display("FAIL bmp_btb got we=%b addr=%0d want we=1 addr=16", btbwe, btbaddr); end
        n_checks++; if (btbdata !== 32'h80) begin n_fail++; $display("FAIL bmp_btbdata got %h want 80", btbdata); end
        n_checks++; if ({phtwe, phtinc, phtaddr} !== {1'b1, 1'b1, 5'd3}) begin n_fail++; $display("FAIL bmp_pht got we=%b inc=%b addr=%0d want 1 1 3", phtwe, phtinc, phtaddr); end
        n_checks++; if (ghrrst !== 1'b1) begin n_fail++; $display("FAIL bmp_ghr got %b want 1", ghrrst); end
        step(); exp_br++; exp_mp++;
        check_counts("bmp");
    endtask

    task automatic test_branch_correct();
        load_e(32'h40, 1'b1, 32'h80, 5'd7);
        opE_i = OP_BR; ActualTakenE_i = 1'b1; TargetE_i = 32'h80;
        #1;
        n_checks++; if ({mp, btbwe, ghrrst} !== 3'b000) begin n_fail++; $display("FAIL bok_strobes got mp=%b btbwe=%b ghr=%b want 000", mp, btbwe, ghrrst); end
        n_checks++; if (pccorr !== 32'h0) begin n_fail++; $display("FAIL bok_pccorr got %h want 0", pccorr); end
        n_checks++; if ({phtwe, phtinc, phtaddr} !== {1'b1, 1'b1, 5'd7}) begin n_fail++; $display("FAIL bok_pht got we=%b inc=%b addr=%0d want 1 1 7", phtwe, phtinc, phtaddr); end
        step(); exp_br++;
        check_counts("bok");
    endtask

    task automatic test_jumps();
        load_e(32'h100, 1'b1, 32'h200, 5'd0);
        opE_i = OP_JALR; ActualTakenE_i = 1'b0; TargetE_i = 32'h204;
        #1;
        n_checks++; if ({mp, pccorr} !== {1'b1, 32'h204}) begin n_fail++; $display("FAIL jalr_redirect got mp=%b pc=%h want 1 204", mp, pccorr); end
        n_checks++; if ({btbwe, btbaddr, btbdata} !== {1'b1, 5'd0, 32'h204}) begin n_fail++; $display("FAIL jalr_btb got we=%b addr=%0d data=%h want 1 0 204", btbwe, btbaddr, btbdata); end
        n_checks++; if (phtwe !== 1'b0) begin n_fail++; $display("FAIL jalr_phtwe got %b want 0", phtwe); end
        step(); exp_br++; exp_mp++;
        load_e(32'h20, 1'b1, 32'h60, 5'd1);
        opE_i = OP_JAL; TargetE_i = 32'h60;
        #1;
        n_checks++; if ({mp, btbwe, phtwe, ghrrst} !== 4'b0) begin n_fail++; $display("FAIL jal_ok got mp=%b btbwe=%b phtwe=%b ghr=%b want 0000", mp, btbwe, phtwe, ghrrst); end
        step(); exp_br++;
        check_counts("jmp");
    endtask

    task automatic test_not_taken_wrap();
        load_e(32'hFFFF_FFFC, 1'b1, 32'h10, 5'd9);
        opE_i = OP_BR; ActualTakenE_i = 1'b0; TargetE_i = 32'h10;
        #1;
        n_checks++; if ({mp, pccorr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL wrap_redirect got mp=%b pc=%h want 1 00000000", mp, pccorr); end
        n_checks++; if (btbwe !== 1'b0) begin n_fail++; $display("FAIL wrap_btbwe got %b want 0", btbwe); end
        n_checks++; if ({phtwe, phtinc, phtaddr} !== {1'b1, 1'b0, 5'd9}) begin n_fail++; $display("FAIL wrap_pht got we=%b inc=%b addr=%0d want 1 0 9", phtwe, phtinc, phtaddr); end
        step(); exp_br++; exp_mp++;
        load_e(32'h44, 1'b0, 32'h0, 5'd2);
        opE_i = OP_BR; ActualTakenE_i = 1'b0; TargetE_i = 32'h88;
        #1;
        n_checks++; if ({mp, btbwe, phtwe, phtinc} !== 4'b0010) begin n_fail++; $display("FAIL nt_ok got mp=%b btbwe=%b phtwe=%b inc=%b want 0010", mp, btbwe, phtwe, phtinc); end
        step(); exp_br++;
        check_counts("nt");
    endtask

    task automatic test_stall_hold();
        @(negedge clk);
        opE_i = OP_ALU; PCF_i = 32'h40; BranchTakenF_i = 1'b0; BTBtargetF_i = 32'h0; PHTreadaddressF_i = 5'd2;
        @(negedge clk);
        StallD_i = 1'b1; PCF_i = 32'h80; BranchTakenF_i = 1'b1; BTBtargetF_i = 32'h100; PHTreadaddressF_i = 5'd4;
        @(negedge clk);
        StallD_i = 1'b0;
        @(negedge clk);
        opE_i = OP_BR; ActualTakenE_i = 1'b0; TargetE_i = 32'h44;
        #1;
        n_checks++; if ({mp, phtwe, phtaddr} !== {1'b0, 1'b1, 5'd2}) begin n_fail++; $display("FAIL stall_hold got mp=%b phtwe=%b addr=%0d want 0 1 2", mp, phtwe, phtaddr); end
        step(); exp_br++;
    endtask

    task automatic test_flush();
        @(negedge clk);
        opE_i = OP_ALU; PCF_i = 32'h300; BranchTakenF_i = 1'b1; BTBtargetF_i = 32'h500; PHTreadaddressF_i = 5'd6;
        StallD_i = 1'b1; FlushD_i = 1'b1;
        @(negedge clk);
        StallD_i = 1'b0; FlushD_i = 1'b0;
        @(negedge clk);
        opE_i = OP_BR; ActualTakenE_i = 1'b1; TargetE_i = 32'h999;
        #1;
        n_checks++; if ({mp, btbwe, phtwe, ghrrst} !== 4'b0) begin n_fail++; $display("FAIL flushd_strobes got mp=%b btbwe=%b phtwe=%b ghr=%b want 0000", mp, btbwe, phtwe, ghrrst); end
        @(negedge clk);
        opE_i = OP_ALU;
        #1;
        n_checks++; if ({mp, btbwe, phtwe, ghrrst} !== 4'b0) begin n_fail++; $display("FAIL alu_strobes got mp=%b btbwe=%b phtwe=%b ghr=%b want 0000", mp, btbwe, phtwe, ghrrst); end
        FlushE_i = 1'b1;
        @(negedge clk);
        FlushE_i = 1'b0; opE_i = OP_BR; ActualTakenE_i = 1'b1; TargetE_i = 32'h10;
        #1;
        n_checks++; if ({mp, phtwe} !== 2'b00) begin n_fail++; $display("FAIL flushe_strobes got mp=%b phtwe=%b want 00", mp, phtwe); end
        step();
        check_counts("flush");
    endtask

    task automatic test_reset_mid();
        load_e(32'h40, 1'b0, 32'h0, 5'd3);
        opE_i = OP_BR; ActualTakenE_i = 1'b1; TargetE_i = 32'h80;
        #1;
        reset_i = 1'b1;
        #1;
        n_checks++; if ({mp, btbwe, phtwe, phtinc, ghrrst, pccorr} !== 37'h0) begin n_fail++; $display("FAIL rmid_outputs got mp=%b btbwe=%b phtwe=%b pc=%h want all 0", mp, btbwe, phtwe, pccorr); end
        exp_br = 0; exp_mp = 0;
        check_counts("rmid");
        n_checks++; if ({d4_brcnt, d4_mpcnt} !== 8'h00) begin n_fail++; $display("FAIL rmid_cnt4 got %0d/%0d want 0/0", d4_brcnt, d4_mpcnt); end
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        n_checks++; if ({mp, phtwe} !== 2'b00) begin n_fail++; $display("FAIL rmid_after got mp=%b phtwe=%b want 00", mp, phtwe); end
    endtask

    task automatic test_saturate();
        load_e(32'h40, 1'b0, 32'h0, 5'd1);
        opE_i = OP_JAL; TargetE_i = 32'h80;
        repeat (20) @(negedge clk);
        opE_i = OP_ALU;
        #1;
        exp_br = 20; exp_mp = 20;
        check_counts("sat32");
        n_checks++; if (d4_brcnt !== 4'd15) begin n_fail++; $display("FAIL sat4_brcnt got %0d want 15", d4_brcnt); end
        n_checks++; if (d4_mpcnt !== 4'd15) begin n_fail++; $display("FAIL sat4_mpcnt got %0d want 15", d4_mpcnt); end
    endtask

    initial begin
        test_reset();
        test_branch_mispredict();
        test_branch_correct();
        test_jumps();
        test_not_taken_wrap();
        test_stall_hold();
        test_flush();
        n_checks++; if ({d4_brcnt, d4_mpcnt} !== {4'(exp_br), 4'(exp_mp)}) begin n_fail++; $display("FAIL cnt4_track got %0d/%0d want %0d/%0d", d4_brcnt, d4_mpcnt, exp_br, exp_mp); end
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
